// File: rtl/mmu_alloc_arbiter_pkg.sv
// Widths, response FSM encoding and small helpers shared by the MMU allocation arbiter.
package mmu_alloc_arbiter_pkg;
    localparam int REQ_ID_WIDTH        = 7;
    localparam int REQ_SIZE_TYPE_WIDTH = 4;
    localparam int ALL_PAGE_IDX_WIDTH  = 8;
    localparam int FAIL_REASON_WIDTH   = 2;
    localparam int PORT_TAG_WIDTH      = 2;
    localparam int LOCAL_ID_WIDTH      = REQ_ID_WIDTH - PORT_TAG_WIDTH;
    localparam int CNT_WIDTH           = 4;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_HOLD = 2'd2
    } rsp_state_e;

    function automatic logic [3:0] port_onehot(input logic [PORT_TAG_WIDTH-1:0] port);
        port_onehot = 4'b0001 << port;
    endfunction
endpackage

// File: rtl/mmu_alloc_arbiter_rr_arbiter4.sv
// Four-way round-robin arbiter: scans requests starting at i_ptr, grants the first one found.
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant,
    output logic [1:0] o_grant_idx,
    output logic       o_grant_any
);
    logic [1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_idx       = i_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!o_grant_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                o_grant_any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mmu_alloc_arbiter.sv
// Arbitrates four requesters onto the MMU alloc request FIFO and routes one response at a time back.
module mmu_alloc_arbiter
    import mmu_alloc_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3:0]                           req_valid,
    output logic [3:0]                           req_ready,
    input  logic [4*LOCAL_ID_WIDTH-1:0]          req_local_id,
    input  logic [4*REQ_SIZE_TYPE_WIDTH-1:0]     req_page_count,
    output logic                                 alloc_req_submit,
    output logic [REQ_ID_WIDTH-1:0]              alloc_req_id,
    output logic [REQ_SIZE_TYPE_WIDTH-1:0]       alloc_req_page_count,
    input  logic                                 alloc_req_fifo_full,
    input  logic                                 alloc_rsp_fifo_not_empty,
    output logic                                 alloc_rsp_pop,
    input  logic [REQ_ID_WIDTH-1:0]              alloc_rsp_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0]        alloc_rsp_page_idx,
    input  logic                                 alloc_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]         alloc_rsp_fail_reason,
    output logic [3:0]                           rsp_valid,
    input  logic [3:0]                           rsp_ready,
    output logic [LOCAL_ID_WIDTH-1:0]            rsp_local_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0]        rsp_page_idx,
    output logic                                 rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0]         rsp_fail_reason,
    output logic [4*CNT_WIDTH-1:0]               outstanding_cnt,
    output logic                                 err_unexpected_rsp,
    output logic [1:0]                           dbg_rsp_state
);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    // Handshakes: a request transfers when req_valid[p] & req_ready[p]; a response transfers
    // when rsp_valid[p] & rsp_ready[p]. Once raised, rsp_valid and its data hold until transfer.
    logic [CNT_WIDTH-1:0]          r_cnt [4];
    logic [1:0]                    r_rr_ptr;
    rsp_state_e                    r_state;
    rsp_state_e                    w_next_state;
    logic [3:0]                    r_rsp_valid;
    logic [LOCAL_ID_WIDTH-1:0]     r_rsp_local_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] r_rsp_page_idx;
    logic                          r_rsp_fail;
    logic [FAIL_REASON_WIDTH-1:0]  r_rsp_fail_reason;
    logic                          r_err;

    logic [3:0]                    w_eligible;
    logic [3:0]                    w_arb_req;
    logic [3:0]                    w_grant;
    logic [1:0]                    w_grant_idx;
    logic                          w_grant_any;
    logic [3:0]                    w_rsp_hs;
    logic                          w_rsp_hs_any;
    logic                          w_pop;
    logic [PORT_TAG_WIDTH-1:0]     w_rsp_tag;

    always_comb begin
        w_eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_eligible[p] = req_valid[p] && (r_cnt[p] < MAX_CNT);
        end
    end

    assign w_arb_req = (rst || alloc_req_fifo_full) ? 4'b0000 : w_eligible;

    rr_arbiter4 u_rr_arbiter4 (
        .i_req       (w_arb_req),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    assign req_ready            = w_grant;
    assign alloc_req_submit     = w_grant_any;
    assign alloc_req_id         = w_grant_any
        ? {w_grant_idx, req_local_id[w_grant_idx*LOCAL_ID_WIDTH +: LOCAL_ID_WIDTH]}
        : '0;
    assign alloc_req_page_count = w_grant_any
        ? req_page_count[w_grant_idx*REQ_SIZE_TYPE_WIDTH +: REQ_SIZE_TYPE_WIDTH]
        : '0;

    assign w_rsp_hs     = r_rsp_valid & rsp_ready;
    assign w_rsp_hs_any = |w_rsp_hs;
    assign w_rsp_tag    = alloc_rsp_id[REQ_ID_WIDTH-1 -: PORT_TAG_WIDTH];

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            RSP_IDLE: begin
                if (alloc_rsp_fifo_not_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = RSP_WAIT;
                end
            end
            RSP_WAIT: w_next_state = RSP_HOLD;
            RSP_HOLD: begin
                if (w_rsp_hs_any) begin
                    if (alloc_rsp_fifo_not_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = RSP_WAIT;
                    end else begin
                        w_next_state = RSP_IDLE;
                    end
                end
            end
            default: w_next_state = RSP_IDLE;
        endcase
    end

    assign alloc_rsp_pop = w_pop && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RSP_IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_any) begin
                r_rr_ptr <= w_grant_idx + 2'd1;
            end
        end
    end

    // The FIFO presents the popped entry during WAIT; it is latched and steered to its port then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid       <= '0;
            r_rsp_local_id    <= '0;
            r_rsp_page_idx    <= '0;
            r_rsp_fail        <= 1'b0;
            r_rsp_fail_reason <= '0;
            r_err             <= 1'b0;
        end else if (r_state == RSP_WAIT) begin
            r_rsp_valid       <= port_onehot(w_rsp_tag);
            r_rsp_local_id    <= alloc_rsp_id[LOCAL_ID_WIDTH-1:0];
            r_rsp_page_idx    <= alloc_rsp_page_idx;
            r_rsp_fail        <= alloc_rsp_fail;
            r_rsp_fail_reason <= alloc_rsp_fail_reason;
            if (r_cnt[w_rsp_tag] == '0) begin
                r_err <= 1'b1;
            end
        end else if (w_rsp_hs_any) begin
            r_rsp_valid <= '0;
        end
    end

    // A grant and a response on the same port cancel out; a lone response never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_grant[p] && !w_rsp_hs[p]) begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end else if (w_rsp_hs[p] && !w_grant[p] && (r_cnt[p] != '0)) begin
                    r_cnt[p] <= r_cnt[p] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        outstanding_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            outstanding_cnt[p*CNT_WIDTH +: CNT_WIDTH] = r_cnt[p];
        end
    end

    assign rsp_valid          = r_rsp_valid;
    assign rsp_local_id       = r_rsp_local_id;
    assign rsp_page_idx       = r_rsp_page_idx;
    assign rsp_fail           = r_rsp_fail;
    assign rsp_fail_reason    = r_rsp_fail_reason;
    assign err_unexpected_rsp = r_err;
    assign dbg_rsp_state      = r_state;

    a_no_pop_in_wait : assert property (@(posedge clk) disable iff (rst)
        !(r_state == RSP_WAIT && alloc_rsp_pop));
    a_rsp_valid_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(r_rsp_valid));
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
endmodule
